// File: rtl/mul_arbiter_if.sv
// Requester/consumer handshake bundle for mul_arbiter.
// The master side drives requests and result-ready. The slave side is the arbiter.
interface mul_arbiter_if #(
    parameter int unsigned NREQ = 4
) ();
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic [23:0]       res_data;
    logic [IDW-1:0]    res_id;
    logic              res_ready;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/mul_arbiter.sv
// Shares one registered signed 8x8 multiplier between NREQ requesters.
// Define MUL_ARB_RR_EN for round-robin grant; otherwise the lowest index wins.
module mul_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic         clk,
    input  logic         rst_n,  // active-high asynchronous reset
    mul_arbiter_if.slave bus
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic                  adv;
    logic                  grant_found;
    logic [IDW-1:0]        grant_idx;
    logic [IDW-1:0]        start_idx;
    logic signed [7:0]     a_sel, b_sel;

    logic signed [7:0]     a1_q, a1_d, b1_q, b1_d;
    logic [IDW-1:0]        id1_q, id1_d;
    logic                  v1_q, v1_d;
    logic [23:0]           res_data_q, res_data_d;
    logic [IDW-1:0]        res_id_q, res_id_d;
    logic                  res_valid_q, res_valid_d;
    logic signed [15:0]    prod;

`ifdef MUL_ARB_RR_EN
    logic [IDW-1:0]        ptr_q, ptr_d;
    assign start_idx = ptr_q;
`else
    assign start_idx = '0;
`endif

    assign adv = !res_valid_q || bus.res_ready;

    // Circular search starting at start_idx; the first valid requester wins.
    always_comb begin
        int unsigned idx;
        logic [IDW-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        cand        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx  = (32'(start_idx) + k) % NREQ;
            cand = IDW'(idx);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (grant_found && adv && !rst_n) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    assign a_sel = bus.req_a[{grant_idx, 3'b000} +: 8];
    assign b_sel = bus.req_b[{grant_idx, 3'b000} +: 8];

    always_comb begin
        v1_d  = v1_q;
        a1_d  = a1_q;
        b1_d  = b1_q;
        id1_d = id1_q;
        if (adv) begin
            v1_d = grant_found;
            if (grant_found) begin
                a1_d  = a_sel;
                b1_d  = b_sel;
                id1_d = grant_idx;
            end
        end
    end

`ifdef MUL_ARB_RR_EN
    always_comb begin
        ptr_d = ptr_q;
        if (adv && grant_found) begin
            ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    assign prod = a1_q * b1_q;

    always_comb begin
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
        if (adv) begin
            res_data_d  = {{8{prod[15]}}, prod};
            res_id_d    = id1_q;
            res_valid_d = v1_q;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            v1_q        <= 1'b0;
            a1_q        <= '0;
            b1_q        <= '0;
            id1_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else begin
            v1_q        <= v1_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            id1_q       <= id1_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

`ifdef MUL_ARB_RR_EN
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
endmodule
